// File: rtl/seq_shift_add_mult32.sv
// seq_shift_add_mult32
//   Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier. It retires one product
//   bit per clock through an internal carry-select adder. A start/done handshake fronts it,
//   and it sits in the ALU execute path.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; aborts any in-flight operation
//   start    request, sampled only while idle
//   a        multiplicand, captured when start is accepted
//   b        multiplier, captured when start is accepted
//   busy     high from acceptance until the done cycle inclusive
//   done     one-cycle pulse; product is valid
//   product  {hi, lo}; holds its value until the next accepted start
//   hi_nz    product[63:32] != 0, i.e. the result does not fit in WIDTH bits
//
// Timing: start is accepted at edge E. 32 CALC edges follow, so done is high in the cycle
// after edge E+32. The unit returns to idle one edge later, giving one multiply every 34
// cycles.

module seq_shift_add_mult32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nz
);

  localparam int unsigned           BlkW    = 4;
  localparam int unsigned           NumBlk  = WIDTH / BlkW;
  localparam logic [CNT_W-1:0]      CntLast = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  // Adder operands: A = hi, B = multiplicand gated by the current multiplier bit, Cin = 0.
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic [NumBlk:0]  w_carry;
  logic             w_cout;

  assign w_addend   = r_lo[0] ? r_m : '0;
  assign w_carry[0] = 1'b0;

  // Carry-select adder. Each 4-bit block precomputes its sum for both carry-in values, and
  // the incoming block carry then selects between them.
  for (genvar g = 0; g < NumBlk; g++) begin : g_csa
    logic [BlkW:0] w_s0;
    logic [BlkW:0] w_s1;

    assign w_s0 = {1'b0, r_hi[g*BlkW +: BlkW]} + {1'b0, w_addend[g*BlkW +: BlkW]};
    assign w_s1 = {1'b0, r_hi[g*BlkW +: BlkW]} + {1'b0, w_addend[g*BlkW +: BlkW]}
                  + (BlkW + 1)'(1);

    assign w_sum[g*BlkW +: BlkW] = w_carry[g] ? w_s1[BlkW-1:0] : w_s0[BlkW-1:0];
    assign w_carry[g+1]          = w_carry[g] ? w_s1[BlkW]     : w_s0[BlkW];
  end

  assign w_cout = w_carry[NumBlk];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_m     <= a;
            r_hi    <= '0;
            r_lo    <= b;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          // The carry-out becomes the new MSB of hi, so no carry is ever lost. The sum LSB
          // shifts into lo, replacing the multiplier bit that was just consumed.
          r_hi    <= {w_cout, w_sum[WIDTH-1:1]};
          r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_count <= r_count + CNT_W'(1);
          if (r_count == CntLast) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          // Any start seen in this cycle is dropped. The unit always passes through idle.
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = {r_hi, r_lo};
  assign hi_nz   = |r_hi;

endmodule
